// File: rtl/cb_bitop_seq_pkg.sv
// Shared definitions for the CB-prefix bit-operation sequencer and its external ALU.
package cb_bitop_seq_pkg;

  typedef enum logic [1:0] {
    FN_ILL = 2'd0,
    FN_BIT = 2'd1,
    FN_RES = 2'd2,
    FN_SET = 2'd3
  } alu_fn_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_R,
    ST_FETCH_M,
    ST_EXEC,
    ST_WB_R,
    ST_WB_M,
    ST_DONE
  } state_e;

  localparam logic [2:0] REG_HL_IND = 3'd6;

endpackage

// File: rtl/cb_bitop_seq.sv
// Sequencer for CB-prefixed BIT/RES/SET: operand fetch from register file or (HL),
// external ALU evaluation, write-back, and Z flag update.
module cb_bitop_seq
  import cb_bitop_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] opcode,
  output logic       busy,
  output logic [2:0] reg_sel,
  input  logic [7:0] reg_rdata,
  output logic       reg_we,
  output logic [7:0] reg_wdata,
  output logic       mem_re,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic [1:0] alu_fn,
  output logic [7:0] alu_a,
  output logic [2:0] alu_b,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  output logic       done,
  output logic       err,
  output logic       flags_we,
  output logic       flag_z
);

  state_e     state, state_d;
  logic [7:0] op_q;
  logic [7:0] operand_q;
  logic [7:0] result_q;
  logic       zero_q;

  logic       op_ld, operand_ld, res_ld;
  alu_fn_e    fn_q;
  logic       ind_q;

  assign fn_q  = alu_fn_e'(op_q[7:6]);
  assign ind_q = (op_q[2:0] == REG_HL_IND);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      operand_q <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
    end else begin
      state <= state_d;
      if (op_ld)      op_q      <= opcode;
      if (operand_ld) operand_q <= (state == ST_FETCH_M) ? mem_rdata : reg_rdata;
      if (res_ld) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
      end
    end
  end

  always_comb begin
    state_d    = state;
    op_ld      = 1'b0;
    operand_ld = 1'b0;
    res_ld     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          op_ld = 1'b1;
          if (opcode[7:6] == FN_ILL)
            state_d = ST_DONE;
          else if (opcode[2:0] == REG_HL_IND)
            state_d = ST_FETCH_M;
          else
            state_d = ST_FETCH_R;
        end
      end
      ST_FETCH_R: begin
        operand_ld = 1'b1;
        state_d    = ST_EXEC;
      end
      ST_FETCH_M: begin
        if (mem_ack) begin
          operand_ld = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_ld = 1'b1;
        if (fn_q == FN_BIT)
          state_d = ST_DONE;
        else if (ind_q)
          state_d = ST_WB_M;
        else
          state_d = ST_WB_R;
      end
      ST_WB_R: state_d = ST_DONE;
      ST_WB_M: begin
        if (mem_ack) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode from state alone so reset removes them without waiting for a clock.
  assign busy      = (state != ST_IDLE);
  assign reg_sel   = op_q[2:0];
  assign reg_we    = (state == ST_WB_R);
  assign reg_wdata = result_q;
  assign mem_re    = (state == ST_FETCH_M);
  assign mem_we    = (state == ST_WB_M);
  assign mem_wdata = result_q;
  assign alu_fn    = op_q[7:6];
  assign alu_a     = operand_q;
  assign alu_b     = op_q[5:3];
  assign done      = (state == ST_DONE);
  assign err       = done && (fn_q == FN_ILL);
  assign flags_we  = done && (fn_q == FN_BIT);
  assign flag_z    = flags_we && zero_q;

endmodule

// File: tb/tb_cb_bitop_seq.sv
// Directed bench for cb_bitop_seq with a reference ALU, register file and (HL) responder.
module tb_cb_bitop_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] opcode;
  logic       busy;
  logic [2:0] reg_sel;
  logic [7:0] reg_rdata;
  logic       reg_we;
  logic [7:0] reg_wdata;
  logic       mem_re, mem_we;
  logic [7:0] mem_wdata, mem_rdata;
  logic       mem_ack;
  logic [1:0] alu_fn;
  logic [7:0] alu_a;
  logic [2:0] alu_b;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       done, err, flags_we, flag_z;

  always #5 clk = ~clk;

  cb_bitop_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .busy(busy),
    .reg_sel(reg_sel), .reg_rdata(reg_rdata), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .alu_fn(alu_fn), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .done(done), .err(err),
    .flags_we(flags_we), .flag_z(flag_z)
  );

  // Reference ALU as the parent would provide it.
  logic [7:0] alu_mask;
  always_comb begin
    alu_mask = 8'h01 << alu_b;
    case (alu_fn)
      2'd2:    alu_result = alu_a & ~alu_mask;
      2'd3:    alu_result = alu_a | alu_mask;
      default: alu_result = alu_a;
    endcase
    alu_zero = ~alu_a[alu_b];
  end

  logic [7:0] regs [8];
  assign reg_rdata = regs[reg_sel];

  logic [7:0] mem_byte;
  int         mem_wait;
  int         mcnt;
  assign mem_rdata = mem_byte;

  // Acks a pending (HL) request after mem_wait idle cycles; ack lasts one cycle.
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_re || mem_we) begin
      if (mcnt >= mem_wait) begin
        mem_ack = 1'b1;
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end else begin
      mcnt = 0;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int         lat, n_rwe, rwe_cyc, n_mre, n_mwe, n_done, mw_unstable;
  logic [2:0] rsel;
  logic [7:0] rwdata, mwdata;
  logic       fz, fwe, er;

  task automatic run_op(input logic [7:0] op, input int max_cyc);
    lat = 0; n_rwe = 0; rwe_cyc = 0; n_mre = 0; n_mwe = 0; n_done = 0; mw_unstable = 0;
    rsel = '0; rwdata = '0; mwdata = '0; fz = 1'b0; fwe = 1'b0; er = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    opcode = op;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (reg_we) begin
        n_rwe++;
        rwe_cyc = k;
        rsel    = reg_sel;
        rwdata  = reg_wdata;
      end
      if (mem_re) n_mre++;
      if (mem_we) begin
        if (n_mwe == 0) mwdata = mem_wdata;
        else if (mem_wdata !== mwdata) mw_unstable = 1;
        n_mwe++;
      end
      if (done) begin
        n_done++;
        lat = k;
        fz  = flag_z;
        fwe = flags_we;
        er  = err;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] op;
    logic [7:0] init;
    int         mwait;
    int         lat;
    int         n_rwe;
    int         rwe_cyc;
    logic [2:0] rsel;
    logic [7:0] rwdata;
    int         n_mre;
    int         n_mwe;
    logic [7:0] mwdata;
    logic       fwe;
    logic       fz;
    logic       err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    //        op     init   mw lat rwe cyc rsel rwdata mre mwe mwdata fwe  fz   err
    vecs[0] = '{8'hD8, 8'h00, 0, 4, 1, 3, 3'd0, 8'h08, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h47, 8'h5A, 0, 3, 0, 0, 3'd0, 8'h00, 0, 0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h4F, 8'h5A, 0, 3, 0, 0, 3'd0, 8'h00, 0, 0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 0, 1, 0, 0, 3'd0, 8'h00, 0, 0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'hBE, 8'hFF, 2, 8, 0, 0, 3'd0, 8'h00, 3, 3, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h91, 8'hFF, 0, 4, 1, 3, 3'd1, 8'hFB, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'hE7, 8'h0F, 0, 4, 1, 3, 3'd7, 8'h1F, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'h7E, 8'h80, 0, 3, 0, 0, 3'd0, 8'h00, 1, 0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h3F, 8'h00, 0, 1, 0, 0, 3'd0, 8'h00, 0, 0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{8'hC6, 8'h00, 1, 6, 0, 0, 3'd0, 8'h00, 2, 2, 8'h01, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    mem_byte = 8'h00;
    mem_wait = 0;
    mcnt     = 0;
    mem_ack  = 1'b0;
    start    = 1'b0;
    opcode   = 8'h00;
    reset_n  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_flags_we", flags_we, 0);
    chk("rst_flag_z", flag_z, 0);
    chk("rst_alu_a", alu_a, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      logic [2:0] idx;
      idx = vecs[i].op[2:0];
      if (idx == 3'd6) mem_byte = vecs[i].init;
      else regs[idx] = vecs[i].init;
      mem_wait = vecs[i].mwait;
      run_op(vecs[i].op, 40);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_n_reg_we", i), n_rwe, vecs[i].n_rwe);
      chk($sformatf("v%0d_reg_we_cycle", i), rwe_cyc, vecs[i].rwe_cyc);
      chk($sformatf("v%0d_reg_sel", i), rsel, vecs[i].rsel);
      chk($sformatf("v%0d_reg_wdata", i), rwdata, vecs[i].rwdata);
      chk($sformatf("v%0d_n_mem_re", i), n_mre, vecs[i].n_mre);
      chk($sformatf("v%0d_n_mem_we", i), n_mwe, vecs[i].n_mwe);
      chk($sformatf("v%0d_mem_wdata", i), mwdata, vecs[i].mwdata);
      chk($sformatf("v%0d_mem_wdata_stable", i), mw_unstable, 0);
      chk($sformatf("v%0d_flags_we", i), fwe, vecs[i].fwe);
      chk($sformatf("v%0d_flag_z", i), fz, vecs[i].fz);
      chk($sformatf("v%0d_err", i), er, vecs[i].err);
    end

    // Reset while SET 7,(HL) is waiting for its write ack.
    begin
      int seen_we, bad;
      seen_we  = 0;
      bad      = 0;
      mem_byte = 8'h00;
      mem_wait = 10;
      @(negedge clk);
      start  = 1'b1;
      opcode = 8'hFE;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (k == 1) start = 1'b0;
        if (mem_we) begin
          seen_we = 1;
          break;
        end
      end
      chk("abort_reached_wb_m", seen_we, 1);
      chk("abort_wdata", mem_wdata, 8'h80);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_mem_we_async", mem_we, 0);
      chk("abort_busy_async", busy, 0);
      chk("abort_done_async", done, 0);
      repeat (3) begin
        @(negedge clk);
        if (done || mem_we || reg_we || mem_re || flags_we) bad++;
      end
      chk("abort_no_strobes", bad, 0);
      reset_n  = 1'b1;
      mem_wait = 0;
      regs[0]  = 8'h00;
      run_op(8'hD8, 40);
      chk("post_abort_latency", lat, 4);
      chk("post_abort_n_reg_we", n_rwe, 1);
      chk("post_abort_reg_we_cycle", rwe_cyc, 3);
      chk("post_abort_reg_sel", rsel, 0);
      chk("post_abort_reg_wdata", rwdata, 8'h08);
      chk("post_abort_n_mem_we", n_mwe, 0);
    end

    // start held high across an operation with the opcode changed underneath it.
    begin
      int dones, done_mask, rwe_n, fwe_cyc, busy_k5;
      logic [7:0] wdata_seen;
      logic       z_seen;
      dones = 0; done_mask = 0; rwe_n = 0; fwe_cyc = 0; busy_k5 = 1;
      wdata_seen = '0; z_seen = 1'b0;
      regs[0] = 8'h00;
      regs[7] = 8'h5A;
      @(negedge clk);
      start  = 1'b1;
      opcode = 8'hD8;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (k == 1) opcode = 8'h47;
        if (k == 5) busy_k5 = busy;
        if (k == 6) start = 1'b0;
        if (reg_we) begin
          rwe_n++;
          wdata_seen = reg_wdata;
        end
        if (done) begin
          dones++;
          done_mask |= (1 << k);
        end
        if (flags_we) begin
          fwe_cyc = k;
          z_seen  = flag_z;
        end
      end
      chk("hold_done_count", dones, 2);
      chk("hold_done_cycles", done_mask, (1 << 4) | (1 << 8));
      chk("hold_reg_we_count", rwe_n, 1);
      chk("hold_reg_wdata", wdata_seen, 8'h08);
      chk("hold_idle_gap", busy_k5, 0);
      chk("hold_flags_we_cycle", fwe_cyc, 8);
      chk("hold_flag_z", z_seen, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cb_bitop_seq.md
CB_BITOP_SEQ -- requirements
Module: cb_bitop_seq

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request: execute CB-prefixed opcode on opcode.
REQ-005 opcode  in  8  CB opcode byte; [7:6]=fn, [5:3]=bit index, [2:0]=register index (6 = (HL)).
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 reg_sel  out  3  register-file index (B,C,D,E,H,L,-,A = 0..5,7).
REQ-008 reg_rdata  in  8  combinational register-file read of reg_sel.
REQ-009 reg_we / reg_wdata  out  1/8  register write strobe and data.
REQ-010 mem_re / mem_we / mem_wdata  out  1/1/8  (HL) bus request strobes and write data.
REQ-011 mem_rdata / mem_ack  in  8/1  bus read data; ack completes current mem_re or mem_we.
REQ-012 alu_fn / alu_a / alu_b  out  2/8/3  to external ALU: function (1=BIT, 2=RES, 3=SET), operand, bit index.
REQ-013 alu_result / alu_zero  in  8/1  combinational ALU outputs.
REQ-014 done / err / flags_we / flag_z  out  1 each  completion pulse, illegal-op flag, flag write strobe, Z value.

Function
REQ-015 States: IDLE, FETCH_R, FETCH_M, EXEC, WB_R, WB_M, DONE.
REQ-016 IDLE: start=1 latches opcode; next FETCH_M if [2:0]=6, FETCH_R otherwise; [7:6]=0 goes directly to DONE with err latched.
REQ-017 start outside IDLE (including DONE cycle) is ignored; latched opcode does not change.
REQ-018 FETCH_R: reg_sel=opcode[2:0]; operand latch <= reg_rdata; next EXEC (one cycle).
REQ-019 FETCH_M: mem_re=1 until mem_ack; on mem_ack operand latch <= mem_rdata, next EXEC; no timeout.
REQ-020 EXEC: alu_a=operand latch, alu_b=opcode[5:3], alu_fn=opcode[7:6]; latch alu_result and alu_zero; next DONE for BIT, WB_M for (HL), WB_R otherwise.
REQ-021 WB_R: reg_we=1 for exactly one cycle, reg_sel=opcode[2:0], reg_wdata=result latch; next DONE.
REQ-022 WB_M: mem_we=1, mem_wdata=result latch held stable until mem_ack; next DONE.
REQ-023 DONE: done=1 one cycle; flags_we=1 and flag_z=latched alu_zero only for BIT; err=1 only for illegal op; next IDLE.
REQ-024 mem_ack in any state other than FETCH_M/WB_M is ignored.
REQ-025 Latency from accepting start at T: register RES/SET done at T+4; register BIT done at T+3; illegal done at T+1; (HL) adds mem wait cycles.
REQ-026 BIT never asserts reg_we or mem_we; RES/SET never assert flags_we.
REQ-027 alu_a/alu_b/alu_fn are driven from latches in all states (don't-care outside EXEC but stable).

Reset
REQ-028 reset_n low: state=IDLE immediately; busy, done, err, reg_we, mem_re, mem_we, flags_we, flag_z = 0; latches = 0.
REQ-029 Reset mid-operation aborts without any further write strobe; first start after release is accepted normally.

Structure
REQ-030 Shared ALU package holds alu_fn enum (BIT/RES/SET), state enum, and constant REG_HL_IND = 6.
REQ-031 Single module, no sub-module; ALU is instantiated by the parent, not inside this block.

Verification
REQ-032 opcode 0xD8 (SET 3,B), reg_rdata=0x00, start at T -> reg_we at T+3 with reg_sel=0, reg_wdata=0x08; done at T+4.
REQ-033 opcode 0xBE (RES 7,(HL)), mem_rdata=0xFF, mem_ack after 2 wait cycles on read and write -> mem_we with mem_wdata=0x7F held until ack; done one cycle after write ack.
REQ-034 opcode 0x47 (BIT 0,A), A=0x5A -> no reg_we/mem_we; done at T+3 with flags_we=1, flag_z=1; repeat with BIT 1,A (0x4F) -> flag_z=0.
REQ-035 opcode 0x00 -> done=1, err=1 at T+1; no reg_we, mem_re, mem_we.
REQ-036 reset_n low during WB_M of 0xFE (SET 7,(HL)) -> mem_we and busy drop asynchronously, state IDLE, no done; next 0xD8 completes per REQ-032.
REQ-037 start held high throughout a 0xD8 operation with a different opcode -> second opcode not accepted until IDLE; exactly one done per accepted start.
